// File: rtl/seg_scan_mux.sv
// Time-multiplexed 4-digit seven-segment scanner with per-frame shadow capture,
// inter-digit blanking and optional character rotation.
module seg_scan_mux #(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_CYCLES  = 500,
  parameter int SCROLL_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] segA,
  input  logic [6:0] segB,
  input  logic [6:0] segC,
  input  logic [6:0] segD,
  input  logic       scroll_en,
  output logic [6:0] seg_out,
  output logic [3:0] an_n,
  output logic       frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FCNT_LAST = FW'(SCROLL_FRAMES - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_pos;
  logic [1:0]    r_off;
  logic [FW-1:0] r_fcnt;
  logic [6:0]    r_shadow [4];
  logic [3:0]    r_an_n;
  logic [6:0]    r_seg_out;
  logic          r_frame_tick;

  logic       w_slot_end;
  logic       w_frame_end;
  logic       w_capture;
  logic       w_drive;
  logic [1:0] w_idx;
  logic [3:0] w_an_next;
  logic [6:0] w_seg_next;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_pos == 2'd3);
  assign w_capture   = (r_cnt == '0) && (r_pos == 2'd0);
  assign w_drive     = (r_cnt >= CNT_BLANK);
  // Two-bit add wraps naturally, giving the mod-4 rotation for free.
  assign w_idx       = r_pos + r_off;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_an_next  = 4'b1111;
    w_seg_next = 7'h7F;
    if (w_drive) begin
      w_an_next  = ~(4'b1000 >> r_pos);
      w_seg_next = r_shadow[w_idx];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which is what gives the fixed one-cycle output lag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_pos        <= '0;
      r_off        <= '0;
      r_fcnt       <= '0;
      // NOTE: the shadow bank is only four registers and must read as blank
      // after reset, so it is reset explicitly rather than left as a RAM.
      for (int i = 0; i < 4; i++) r_shadow[i] <= 7'h7F;
      r_an_n       <= 4'b1111;
      r_seg_out    <= 7'h7F;
      r_frame_tick <= 1'b0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_pos <= r_pos + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_capture) begin
        r_shadow[0] <= segA;
        r_shadow[1] <= segB;
        r_shadow[2] <= segC;
        r_shadow[3] <= segD;
      end

      // Offset only moves on the frame boundary so a frame never tears.
      if (w_frame_end) begin
        if (scroll_en) begin
          if (r_fcnt == FCNT_LAST) begin
            r_fcnt <= '0;
            r_off  <= r_off + 2'd1;
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end else begin
          r_fcnt <= '0;
          r_off  <= '0;
        end
      end

      r_an_n       <= w_an_next;
      r_seg_out    <= w_seg_next;
      r_frame_tick <= w_frame_end;
    end
  end

  assign seg_out    = r_seg_out;
  assign an_n       = r_an_n;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: expected per-cycle outputs are queued by
// the stimulus and consumed by independent monitors for two parameter sets.
module tb_seg_scan_mux;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_a, seg_b, seg_c, seg_d;
  logic       scroll_en;
  logic [6:0] a_seg, b_seg;
  logic [3:0] a_an, b_an;
  logic       a_tick, b_tick;

  exp_t qa[$];
  exp_t qb[$];
  bit   mon_a = 1'b0;
  bit   mon_b = 1'b0;
  int   tests = 0;
  int   failed = 0;

  // Hand-computed character order per scroll offset (leftmost first).
  localparam logic [27:0] ROT0 = {7'h40, 7'h79, 7'h24, 7'h30};
  localparam logic [27:0] ROT1 = {7'h79, 7'h24, 7'h30, 7'h40};
  localparam logic [27:0] ROT2 = {7'h24, 7'h30, 7'h40, 7'h79};
  localparam logic [27:0] ROT3 = {7'h30, 7'h40, 7'h79, 7'h24};
  localparam logic [27:0] NEWB = {7'h40, 7'h12, 7'h24, 7'h30};
  localparam logic [15:0] AN_TAB = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  always #5 clk = ~clk;

  seg_scan_mux #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .SCROLL_FRAMES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .segA(seg_a), .segB(seg_b), .segC(seg_c), .segD(seg_d),
    .scroll_en(scroll_en), .seg_out(a_seg), .an_n(a_an), .frame_tick(a_tick)
  );

  seg_scan_mux #(.REFRESH_DIV(2), .BLANK_CYCLES(1), .SCROLL_FRAMES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .segA(seg_a), .segB(seg_b), .segC(seg_c), .segD(seg_d),
    .scroll_en(1'b0), .seg_out(b_seg), .an_n(b_an), .frame_tick(b_tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue one frame: per position, bl blank cycles then rd-bl drive cycles,
  // frame_tick on the very last drive cycle of the rightmost digit.
  task automatic push_frame(input bit to_b, input logic [27:0] chars, input int rd, input int bl);
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < rd; c++) begin
        if (c < bl) e = '{an: 4'b1111, seg: 7'h7F, tick: 1'b0};
        else e = '{an: AN_TAB[15-4*p -: 4], seg: chars[27-7*p -: 7],
                   tick: (p == 3 && c == rd - 1)};
        if (to_b) qb.push_back(e);
        else qa.push_back(e);
      end
    end
  endtask

  initial begin : monitor_a
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_a) begin
        check("a_onehot", 32'($countones(~a_an) <= 1), 32'd1);
        check("a_blank_seg", 32'((a_an != 4'hF) || (a_seg == 7'h7F)), 32'd1);
        if (qa.size() > 0) begin
          e = qa.pop_front();
          check("a_an_seg_tick", {20'd0, a_an, a_seg, a_tick}, {20'd0, e});
        end
      end
    end
  end

  initial begin : monitor_b
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_b) begin
        check("b_onehot", 32'($countones(~b_an) <= 1), 32'd1);
        if (qb.size() > 0) begin
          e = qb.pop_front();
          check("b_an_seg_tick", {20'd0, b_an, b_seg, b_tick}, {20'd0, e});
        end
      end
    end
  end

  initial begin : stimulus
    int offs [16] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 0, 0, 1};
    rst_n = 1'b0;
    scroll_en = 1'b0;
    seg_a = 7'h40; seg_b = 7'h79; seg_c = 7'h24; seg_d = 7'h30;
    repeat (2) @(negedge clk);
    check("rst_a_an", 32'(a_an), 32'hF);
    check("rst_a_seg", 32'(a_seg), 32'h7F);
    check("rst_a_tick", 32'(a_tick), 32'd0);
    check("rst_b_an", 32'(b_an), 32'hF);

    // Basic scan and frame coherency: segB changes during frame 2, pos 0 drive.
    push_frame(1'b0, ROT0, 8, 2);
    push_frame(1'b0, ROT0, 8, 2);
    push_frame(1'b0, NEWB, 8, 2);
    push_frame(1'b0, NEWB, 8, 2);
    @(negedge clk);
    rst_n = 1'b1;
    mon_a = 1'b1;
    repeat (36) @(posedge clk);
    @(negedge clk);
    seg_b = 7'h12;
    repeat (81) @(posedge clk);

    // Edge 117 output is mid-drive of pos 2; reset must blank without a clock.
    #3;
    mon_a = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_an", 32'(a_an), 32'hF);
    check("midrst_seg", 32'(a_seg), 32'h7F);
    check("midrst_tick", 32'(a_tick), 32'd0);
    qa.delete();

    // Scroll from reset, then disable mid-frame at off=2 and re-enable.
    seg_b = 7'h79;
    scroll_en = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 16; f++) begin
      case (offs[f])
        0: push_frame(1'b0, ROT0, 8, 2);
        1: push_frame(1'b0, ROT1, 8, 2);
        2: push_frame(1'b0, ROT2, 8, 2);
        default: push_frame(1'b0, ROT3, 8, 2);
      endcase
      push_frame(1'b1, ROT0, 2, 1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_a = 1'b1;
    mon_b = 1'b1;
    repeat (400) @(posedge clk);
    @(negedge clk);
    scroll_en = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    scroll_en = 1'b1;
    repeat (92) @(posedge clk);
    #3;
    mon_a = 1'b0;
    mon_b = 1'b0;
    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
